// File: rtl/bnn_psum_threshold.sv
// Accumulates per-pixel partial popcounts, applies the folded BN/sign threshold,
// and packs the resulting binary activations LSB-first into handshaked words.
module bnn_psum_threshold #(
    parameter int PSUM_WIDTH = 4,
    parameter int ACC_WIDTH  = 12,
    parameter int PACK_WIDTH = 8,
    parameter int NB_WIDTH   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  psum_valid,
    output logic                  psum_ready,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    input  logic                  psum_last,
    input  logic                  psum_frame_end,
    input  logic                  thr_load,
    input  logic [ACC_WIDTH-1:0]  thr_in,
    input  logic                  thr_pol,
    output logic                  act_valid,
    input  logic                  act_ready,
    output logic [PACK_WIDTH-1:0] act_data,
    output logic [NB_WIDTH-1:0]   act_nbits,
    output logic                  act_frame_end,
    output logic                  busy
);

    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [NB_WIDTH-1:0]   bit_cnt_q, bit_cnt_d;
    logic [PACK_WIDTH-1:0] pack_q, pack_d;
    logic [ACC_WIDTH-1:0]  thr_q, thr_d;
    logic                  thr_pol_q, thr_pol_d;
    logic                  act_valid_q, act_valid_d;
    logic [PACK_WIDTH-1:0] act_data_q, act_data_d;
    logic [NB_WIDTH-1:0]   act_nbits_q, act_nbits_d;
    logic                  act_frame_end_q, act_frame_end_d;

    logic                  accept;
    logic                  word_done;
    logic [ACC_WIDTH:0]    sum_wide;
    logic [ACC_WIDTH-1:0]  sum_sat;
    logic                  act_bit;
    logic [PACK_WIDTH-1:0] pack_with_bit;

    always_comb begin
        psum_ready = !act_valid_q || act_ready;
        accept     = psum_valid && psum_ready;

        // One extra bit catches the carry so a single beat can never wrap.
        sum_wide = {1'b0, acc_q} + (ACC_WIDTH + 1)'(psum_in);
        sum_sat  = sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
        act_bit  = thr_pol_q ? (sum_sat < thr_q) : (sum_sat >= thr_q);

        pack_with_bit = pack_q;
        for (int i = 0; i < PACK_WIDTH; i++) begin
            if (bit_cnt_q == NB_WIDTH'(i)) begin
                pack_with_bit[i] = act_bit;
            end
        end

        word_done = accept && psum_last &&
                    ((bit_cnt_q == NB_WIDTH'(PACK_WIDTH - 1)) || psum_frame_end);

        acc_d           = acc_q;
        bit_cnt_d       = bit_cnt_q;
        pack_d          = pack_q;
        act_valid_d     = act_valid_q;
        act_data_d      = act_data_q;
        act_nbits_d     = act_nbits_q;
        act_frame_end_d = act_frame_end_q;
        thr_d           = thr_q;
        thr_pol_d       = thr_pol_q;

        if (accept) begin
            if (!psum_last) begin
                acc_d = sum_sat;
            end else begin
                acc_d = '0;
                if (word_done) begin
                    pack_d          = '0;
                    bit_cnt_d       = '0;
                    act_data_d      = pack_with_bit;
                    act_nbits_d     = bit_cnt_q + NB_WIDTH'(1);
                    act_frame_end_d = psum_frame_end;
                end else begin
                    pack_d    = pack_with_bit;
                    bit_cnt_d = bit_cnt_q + NB_WIDTH'(1);
                end
            end
        end

        // A word completing on the consume edge keeps valid high (back-to-back).
        if (act_valid_q && act_ready) begin
            act_valid_d = 1'b0;
        end
        if (word_done) begin
            act_valid_d = 1'b1;
        end

        if (thr_load) begin
            thr_d     = thr_in;
            thr_pol_d = thr_pol;
        end

        busy = (acc_q != '0) || (bit_cnt_q != '0) || act_valid_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q           <= '0;
            bit_cnt_q       <= '0;
            pack_q          <= '0;
            thr_q           <= '0;
            thr_pol_q       <= 1'b0;
            act_valid_q     <= 1'b0;
            act_data_q      <= '0;
            act_nbits_q     <= '0;
            act_frame_end_q <= 1'b0;
        end else begin
            acc_q           <= acc_d;
            bit_cnt_q       <= bit_cnt_d;
            pack_q          <= pack_d;
            thr_q           <= thr_d;
            thr_pol_q       <= thr_pol_d;
            act_valid_q     <= act_valid_d;
            act_data_q      <= act_data_d;
            act_nbits_q     <= act_nbits_d;
            act_frame_end_q <= act_frame_end_d;
        end
    end

    assign act_valid     = act_valid_q;
    assign act_data      = act_data_q;
    assign act_nbits     = act_nbits_q;
    assign act_frame_end = act_frame_end_q;

endmodule

// File: tb/tb_bnn_psum_threshold.sv
// Bench for bnn_psum_threshold: drives beats, models sums/threshold/packing
// with plain arithmetic and queues, and compares every emitted word.
module tb_bnn_psum_threshold;
    localparam int PW      = 4;
    localparam int AW      = 12;
    localparam int KW      = 8;
    localparam int NW      = 4;
    localparam int ACC_MAX = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          psum_valid = 1'b0;
    logic          psum_ready;
    logic [PW-1:0] psum_in = '0;
    logic          psum_last = 1'b0;
    logic          psum_frame_end = 1'b0;
    logic          thr_load = 1'b0;
    logic [AW-1:0] thr_in = '0;
    logic          thr_pol = 1'b0;
    logic          act_valid;
    logic          act_ready = 1'b1;
    logic [KW-1:0] act_data;
    logic [NW-1:0] act_nbits;
    logic          act_frame_end;
    logic          busy;

    bnn_psum_threshold #(
        .PSUM_WIDTH(PW), .ACC_WIDTH(AW), .PACK_WIDTH(KW), .NB_WIDTH(NW)
    ) dut (
        .clk(clk), .rst(rst),
        .psum_valid(psum_valid), .psum_ready(psum_ready), .psum_in(psum_in),
        .psum_last(psum_last), .psum_frame_end(psum_frame_end),
        .thr_load(thr_load), .thr_in(thr_in), .thr_pol(thr_pol),
        .act_valid(act_valid), .act_ready(act_ready), .act_data(act_data),
        .act_nbits(act_nbits), .act_frame_end(act_frame_end), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [KW-1:0] data;
        logic [NW-1:0] nbits;
        logic          fe;
    } word_t;

    word_t got_q[$];
    word_t exp_q[$];
    int    tests_run    = 0;
    int    tests_failed = 0;

    int    m_acc = 0;
    int    m_thr = 0;
    bit    m_pol = 1'b0;
    bit    m_bits[$];
    bit    rand_ready = 1'b0;

    // Words are captured mid-cycle, before the edge that consumes them.
    always @(negedge clk) begin
        #2;
        if (!rst && act_valid && act_ready) begin
            got_q.push_back({act_data, act_nbits, act_frame_end});
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
        $fatal(1);
    end

    function automatic void model_reset();
        m_acc = 0;
        m_thr = 0;
        m_pol = 1'b0;
        m_bits.delete();
    endfunction

    function automatic void model_beat(int p, bit last, bit fe);
        int    sum;
        bit    b;
        word_t w;
        sum = m_acc + p;
        if (sum > ACC_MAX) sum = ACC_MAX;
        if (!last) begin
            m_acc = sum;
        end else begin
            b = m_pol ? (sum < m_thr) : (sum >= m_thr);
            m_acc = 0;
            m_bits.push_back(b);
            if (m_bits.size() == KW || fe) begin
                w.data = '0;
                foreach (m_bits[i]) w.data[i] = m_bits[i];
                w.nbits = NW'(m_bits.size());
                w.fe    = fe;
                exp_q.push_back(w);
                m_bits.delete();
            end
        end
    endfunction

    task automatic send_beat(input int p, input bit last, input bit fe,
                             input bit ld, input int lt, input bit lp);
        int waited = 0;
        bit done   = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (rand_ready) act_ready = 1'($urandom_range(0, 1));
            psum_valid     = 1'b1;
            psum_in        = PW'(p);
            psum_last      = last;
            psum_frame_end = fe;
            thr_load       = ld;
            thr_in         = AW'(lt);
            thr_pol        = lp;
            #1;
            if (psum_ready) done = 1'b1;
            @(posedge clk);
            if (done) model_beat(p, last, fe);
            if (ld) begin
                m_thr = lt;
                m_pol = lp;
            end
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL send_timeout: psum_ready=%b, required 1 within 200 cycles", psum_ready);
                    done = 1'b1;
                end
            end
        end
        #1;
        psum_valid = 1'b0;
        thr_load   = 1'b0;
    endtask

    task automatic send(input int p, input bit last, input bit fe);
        send_beat(p, last, fe, 1'b0, 0, 1'b0);
    endtask

    task automatic load_thr(input int t, input bit p);
        @(negedge clk);
        thr_load = 1'b1;
        thr_in   = AW'(t);
        thr_pol  = p;
        @(posedge clk);
        m_thr = t;
        m_pol = p;
        #1;
        thr_load = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        @(negedge clk);
        rand_ready = 1'b0;
        act_ready  = 1'b1;
        #1;
        while (act_valid) begin
            n++;
            if (n > 30) begin
                tests_run++;
                tests_failed++;
                $display("FAIL drain_timeout: act_valid=%b, required 0", act_valid);
                break;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        psum_valid = 1'b1; psum_in = 4'd5; psum_last = 1'b1; psum_frame_end = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        psum_valid = 1'b0;
        model_reset();
        #1;
        tests_run++; if (act_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_act_valid: got %b, required 0", act_valid); end
        tests_run++; if (act_data !== 8'h00) begin tests_failed++; $display("FAIL reset_act_data: got %h, required 00", act_data); end
        tests_run++; if (act_nbits !== 4'd0) begin tests_failed++; $display("FAIL reset_act_nbits: got %0d, required 0", act_nbits); end
        tests_run++; if (act_frame_end !== 1'b0) begin tests_failed++; $display("FAIL reset_act_fe: got %b, required 0", act_frame_end); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b, required 0", busy); end
        tests_run++; if (psum_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_psum_ready: got %b, required 1", psum_ready); end
        repeat (3) @(posedge clk);
        tests_run++; if (got_q.size() != 0) begin tests_failed++; $display("FAIL reset_no_word: got %0d words, required 0", got_q.size()); end

        // Partial pixel and partial word are discarded by a mid-stream reset.
        send(3, 1'b1, 1'b0);
        send(3, 1'b1, 1'b0);
        send(4, 1'b0, 1'b0);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL midreset_busy_before: got %b, required 1", busy); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL midreset_busy_after: got %b, required 0", busy); end
        send(0, 1'b1, 1'b1);
        drain();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL reset_words_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++;
                $display("FAIL reset_word[%0d]: got data=%h nbits=%0d fe=%b, required data=%h nbits=%0d fe=%b", i, got_q[i].data, got_q[i].nbits, got_q[i].fe, exp_q[i].data, exp_q[i].nbits, exp_q[i].fe); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_accumulate();
        load_thr(20, 1'b0);
        repeat (4) begin
            send(9, 1'b0, 1'b0); send(9, 1'b0, 1'b0); send(2, 1'b1, 1'b0);
            send(9, 1'b0, 1'b0); send(9, 1'b0, 1'b0); send(1, 1'b1, 1'b0);
        end
        drain();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL accum_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++;
                $display("FAIL accum_word[%0d]: got data=%h nbits=%0d fe=%b, required data=%h nbits=%0d fe=%b", i, got_q[i].data, got_q[i].nbits, got_q[i].fe, exp_q[i].data, exp_q[i].nbits, exp_q[i].fe); end
        end
        if (got_q.size() > 0) begin
            tests_run++;
            if (got_q[0] !== {8'h55, 4'd8, 1'b0}) begin tests_failed++;
                $display("FAIL accum_0x55: got data=%h nbits=%0d fe=%b, required data=55 nbits=8 fe=0", got_q[0].data, got_q[0].nbits, got_q[0].fe); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_polarity();
        load_thr(20, 1'b1);
        send(9, 1'b0, 1'b0); send(9, 1'b0, 1'b0); send(2, 1'b1, 1'b0);
        send(9, 1'b0, 1'b0); send(9, 1'b0, 1'b0); send(1, 1'b1, 1'b0);
        send(9, 1'b0, 1'b0); send(9, 1'b0, 1'b0);
        send_beat(1, 1'b1, 1'b1, 1'b1, 30, 1'b0);
        // The newly loaded threshold (30, pol 0) governs the following pixels.
        send(15, 1'b0, 1'b0); send(15, 1'b1, 1'b0);
        send(15, 1'b0, 1'b0); send(14, 1'b1, 1'b1);
        drain();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL pol_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++;
                $display("FAIL pol_word[%0d]: got data=%h nbits=%0d fe=%b, required data=%h nbits=%0d fe=%b", i, got_q[i].data, got_q[i].nbits, got_q[i].fe, exp_q[i].data, exp_q[i].nbits, exp_q[i].fe); end
        end
        if (got_q.size() > 0) begin
            tests_run++;
            if (got_q[0] !== {8'h06, 4'd3, 1'b1}) begin tests_failed++;
                $display("FAIL pol_0x06: got data=%h nbits=%0d fe=%b, required data=06 nbits=3 fe=1", got_q[0].data, got_q[0].nbits, got_q[0].fe); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_flush();
        load_thr(20, 1'b0);
        send(15, 1'b0, 1'b0); send(5, 1'b1, 1'b0);
        send(10, 1'b0, 1'b0); send(12, 1'b1, 1'b0);
        send(6, 1'b0, 1'b1);
        send(7, 1'b1, 1'b1);
        drain();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL flush_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++;
                $display("FAIL flush_word[%0d]: got data=%h nbits=%0d fe=%b, required data=%h nbits=%0d fe=%b", i, got_q[i].data, got_q[i].nbits, got_q[i].fe, exp_q[i].data, exp_q[i].nbits, exp_q[i].fe); end
        end
        if (got_q.size() > 0) begin
            tests_run++;
            if (got_q[0] !== {8'h03, 4'd3, 1'b1}) begin tests_failed++;
                $display("FAIL flush_0x03: got data=%h nbits=%0d fe=%b, required data=03 nbits=3 fe=1", got_q[0].data, got_q[0].nbits, got_q[0].fe); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_backpressure();
        word_t held;
        load_thr(8, 1'b0);
        @(negedge clk);
        act_ready = 1'b0;
        for (int i = 0; i < KW; i++) send(int'($urandom_range(0, 15)), 1'b1, 1'b0);
        held = (exp_q.size() > 0) ? exp_q[0] : '0;
        @(negedge clk);
        psum_valid = 1'b1; psum_in = 4'd7; psum_last = 1'b0; psum_frame_end = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            tests_run++; if (psum_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_psum_ready[%0d]: got %b, required 0", c, psum_ready); end
            tests_run++; if (act_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_act_valid[%0d]: got %b, required 1", c, act_valid); end
            tests_run++; if (act_data !== held.data) begin tests_failed++; $display("FAIL bp_act_data[%0d]: got %h, required %h", c, act_data, held.data); end
            @(negedge clk);
        end
        act_ready = 1'b1;
        #1;
        tests_run++; if (psum_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_ready: got %b, required 1", psum_ready); end
        @(posedge clk);
        model_beat(7, 1'b0, 1'b0);
        #1;
        psum_valid = 1'b0;
        tests_run++; if (act_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_consumed: act_valid got %b, required 0", act_valid); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL bp_beat_taken: busy got %b, required 1", busy); end
        send(0, 1'b1, 1'b1);
        drain();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL bp_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++;
                $display("FAIL bp_word[%0d]: got data=%h nbits=%0d fe=%b, required data=%h nbits=%0d fe=%b", i, got_q[i].data, got_q[i].nbits, got_q[i].fe, exp_q[i].data, exp_q[i].nbits, exp_q[i].fe); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_back_to_back();
        longint t0;
        longint t1;
        load_thr(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        @(negedge clk);
        act_ready = 1'b1;
        send(int'($urandom_range(0, 15)), 1'b1, 1'b1);
        t0 = longint'($time);
        for (int i = 0; i < 9; i++) begin
            tests_run++; if (act_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_valid[%0d]: got %b, required 1", i, act_valid); end
            send(int'($urandom_range(0, 15)), 1'b1, 1'b1);
        end
        t1 = longint'($time);
        tests_run++; if (t1 - t0 != 90) begin tests_failed++; $display("FAIL b2b_throughput: got %0d time units for 9 beats, required 90", t1 - t0); end
        drain();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL b2b_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++;
                $display("FAIL b2b_word[%0d]: got data=%h nbits=%0d fe=%b, required data=%h nbits=%0d fe=%b", i, got_q[i].data, got_q[i].nbits, got_q[i].fe, exp_q[i].data, exp_q[i].nbits, exp_q[i].fe); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_random();
        rand_ready = 1'b1;
        for (int i = 0; i < 250; i++) begin
            send_beat(int'($urandom_range(0, 15)), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0),
                      int'($urandom_range(0, 60)), 1'($urandom_range(0, 1)));
        end
        rand_ready = 1'b0;
        send(0, 1'b1, 1'b1);
        drain();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL rand_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++;
                $display("FAIL rand_word[%0d]: got data=%h nbits=%0d fe=%b, required data=%h nbits=%0d fe=%b", i, got_q[i].data, got_q[i].nbits, got_q[i].fe, exp_q[i].data, exp_q[i].nbits, exp_q[i].fe); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    task automatic test_saturation();
        load_thr(ACC_MAX, 1'b0);
        repeat (300) send(15, 1'b0, 1'b0);
        send(15, 1'b1, 1'b1);
        repeat (272) send(15, 1'b0, 1'b0);
        send(14, 1'b1, 1'b1);
        drain();
        tests_run++;
        if (got_q.size() != exp_q.size()) begin tests_failed++; $display("FAIL sat_count: got %0d, required %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) if (i < got_q.size()) begin
            tests_run++;
            if (got_q[i] !== exp_q[i]) begin tests_failed++;
                $display("FAIL sat_word[%0d]: got data=%h nbits=%0d fe=%b, required data=%h nbits=%0d fe=%b", i, got_q[i].data, got_q[i].nbits, got_q[i].fe, exp_q[i].data, exp_q[i].nbits, exp_q[i].fe); end
        end
        if (got_q.size() > 0) begin
            tests_run++;
            if (got_q[0].data !== 8'h01) begin tests_failed++; $display("FAIL sat_clamp: got data=%h, required 01", got_q[0].data); end
        end
        got_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_polarity();
        test_flush();
        test_backpressure();
        test_back_to_back();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/bnn_psum_threshold.md
# bnn_psum_threshold

Downstream stage of the XNOR convolution PE column: it consumes the per-column partial popcount leaving the bottom PE (`pcountout`). It accumulates that popcount across input-channel passes into a full pre-activation sum and applies the folded batch-norm/sign threshold to produce one binary activation per output pixel. It packs activations LSB-first into words for the next layer's input buffer, using a valid/ready handshake on both sides.

## Interface
- `PSUM_WIDTH`, 4: width of incoming partial popcount; matches the PE array setting.
- `ACC_WIDTH`, 12: accumulator and threshold width; accumulator saturates.
- `PACK_WIDTH`, 8: activation bits per output word.
- `NB_WIDTH`, 4: width of `act_nbits`; must be ≥ clog2(PACK_WIDTH+1).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `psum_valid`  in  1  `psum_in` is valid this cycle.
- `psum_ready`  out  1  stage can accept a beat.
- `psum_in`  in  PSUM_WIDTH  partial popcount from the PE column.
- `psum_last`  in  1  beat is the final channel pass for the current pixel.
- `psum_frame_end`  in  1  with `psum_last`: last pixel of the row/frame; forces flush of a partial word.
- `thr_load`  in  1  load threshold and polarity.
- `thr_in`  in  ACC_WIDTH  threshold value.
- `thr_pol`  in  1  0: act = (sum ≥ thr); 1: act = (sum < thr) (negative BN gamma).
- `act_valid`  out  1  output word valid.
- `act_ready`  in  1  consumer accepts the word.
- `act_data`  out  PACK_WIDTH  packed activations, bit 0 = earliest pixel, unused bits 0.
- `act_nbits`  out  NB_WIDTH  number of valid bits in `act_data` (1..PACK_WIDTH).
- `act_frame_end`  out  1  word closes a frame.
- `busy`  out  1  accumulator or pack register holds uncommitted data.

## Operation
- Accept = `psum_valid && psum_ready`. `psum_ready = !act_valid || act_ready` (combinational). Beats presented while not ready are held by the producer, not dropped.
- Accepted beat, `psum_last`=0: `acc <= sat(acc + psum_in)`. The saturation ceiling is 2^ACC_WIDTH−1, unsigned.
- Accepted beat, `psum_last`=1:
  - `sum = sat(acc + psum_in)`; `bit = thr_pol ? (sum < thr) : (sum >= thr)`.
  - `bit` is written at position `bit_cnt` of the pack register; `acc <= 0`.
- Word completion occurs on a last-beat acceptance when `bit_cnt == PACK_WIDTH−1` or `psum_frame_end`=1. On completion:
  - The output register loads the pack register including the new bit.
  - `act_nbits = bit_cnt+1`; `act_frame_end = psum_frame_end`; `act_valid <= 1`.
  - The pack register and `bit_cnt` clear.
- Otherwise a last beat increments `bit_cnt`.
- `psum_frame_end` without `psum_last` is ignored.
- Output handshake: `act_valid` drops the cycle after `act_valid && act_ready` unless a new word completes on that same edge. In that case `act_valid` stays 1 and the new word is presented (back-to-back).
- Threshold: `thr_load` registers `thr_in`/`thr_pol` on the edge. A last beat accepted on the same edge compares against the old threshold.
- `busy = (acc != 0) || (bit_cnt != 0) || act_valid`.

## Timing
- Reset (one cycle `rst`=1) clears everything:
  - `acc`, `bit_cnt`, pack register, threshold and polarity are set to 0.
  - `act_valid`=0, `act_data`=0, `act_nbits`=0, `act_frame_end`=0, `busy`=0.
  - `psum_ready`=1 in the cycle after reset.
- Reset mid-pixel or mid-word discards all partial data. No word is emitted.
- Latency: a word completing on edge N shows `act_valid`=1 after edge N; no extra pipeline stage.
- Stall: while `act_valid`=1 and `act_ready`=0, `psum_ready`=0. `acc`, `bit_cnt` and the pack register hold.
- Throughput: one beat per cycle sustained with `act_ready` held at 1.
- Saturation boundary: `acc` = max plus any `psum_in` gives max; a single beat never wraps.
- Equality `sum == thr`: act=1 for `thr_pol`=0, act=0 for `thr_pol`=1.

## Test plan
- Reset: assert `rst` with `psum_valid`=1 → all outputs 0, `psum_ready`=1 the cycle after deassert, no word emitted.
- Accumulate/threshold, with thr=20, pol=0 and PACK_WIDTH=8:
  - Pixel 1 is beats 9,9,2(last), sum 20 → bit 1. Pixel 2 is beats 9,9,1(last) → bit 0.
  - Repeat the pair 4×, then verify `act_data`=0x55, `act_nbits`=8, `act_frame_end`=0.
- Polarity and equality: with thr=20, pol=1, the sum-20 pixel gives bit 0 and a sum-19 pixel gives bit 1. A `thr_load` coincident with the last beat must use the prior threshold.
- Partial flush: 3 pixels with bits 1,1,0, the third carrying `psum_frame_end` → `act_data`=0x03, `act_nbits`=3, `act_frame_end`=1.
- Backpressure:
  - Hold `act_ready`=0 after a word completes → `psum_ready`=0, state frozen, `act_data` stable.
  - Release `act_ready` → word consumed and next beat accepted the same cycle.
  - With `act_ready`=1 throughout, back-to-back words keep `act_valid` continuously high.
- Saturation: ACC_WIDTH=4, beats 15,15,15(last), thr=15 → sum clamps at 15 and bit=1 (no wrap to 13).
